// File: rtl/reg_hazard_ctrl.sv
// Register-file hazard/forwarding controller: tracks outstanding long writes,
// stalls issue on RAW/WAW/capacity, drives bypass selects. Option: HAZARD_STATS_EN.
module reg_hazard_ctrl #(
    parameter int CNT_W   = 2,
    parameter int MAX_OUT = 4,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_rs1,
    input  logic [4:0]        issue_rs2,
    input  logic              issue_rs1_used,
    input  logic              issue_rs2_used,
    input  logic [4:0]        issue_rd,
    input  logic              issue_we,
    input  logic              issue_long,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic              fwd1,
    output logic              fwd2,
    output logic              pending_any,
    output logic              err,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int TOT_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_pend [32];
    logic [TOT_W-1:0] r_total;
    logic [4:0]       r_last_rd;
    logic             r_last_we;
    logic             r_err;

    logic [CNT_W-1:0] w_p1, w_p2, w_prd, w_pwb;
    logic             w_ret1, w_ret2, w_retd;
    logic             w_haz1, w_haz2, w_waw;
    logic             w_long_wr, w_full, w_ovf;
    logic             w_stall, w_accept;
    logic             w_inc, w_dec;
    logic [31:0]      w_inc_v, w_dec_v;

    assign w_p1  = r_pend[issue_rs1];
    assign w_p2  = r_pend[issue_rs2];
    assign w_prd = r_pend[issue_rd];
    assign w_pwb = r_pend[wb_rd];

    // Retire: the final outstanding write to that register lands this cycle
    assign w_ret1 = wb_valid & (wb_rd == issue_rs1) & (w_p1 == PEND_ONE);
    assign w_ret2 = wb_valid & (wb_rd == issue_rs2) & (w_p2 == PEND_ONE);
    assign w_retd = wb_valid & (wb_rd == issue_rd) & (w_prd == PEND_ONE);

    assign w_haz1 = issue_rs1_used & (issue_rs1 != 5'd0)
                  & (w_p1 != '0) & ~w_ret1;
    assign w_haz2 = issue_rs2_used & (issue_rs2 != 5'd0)
                  & (w_p2 != '0) & ~w_ret2;
    assign w_waw  = issue_we & (issue_rd != 5'd0)
                  & (w_prd != '0) & ~w_retd;

    assign w_long_wr = issue_long & issue_we & (issue_rd != 5'd0);
    assign w_full    = w_long_wr & (r_total == TOT_W'(MAX_OUT)) & ~wb_valid;
    assign w_ovf     = w_long_wr & (w_prd == PEND_MAX)
                     & ~(wb_valid & (wb_rd == issue_rd));

    assign w_stall = issue_valid
                   & (w_haz1 | w_haz2 | w_waw | w_full | w_ovf);

    assign issue_ready = ~w_stall;
    assign w_accept    = issue_valid & issue_ready;

    assign w_inc = w_accept & w_long_wr;
    assign w_dec = wb_valid & (wb_rd != 5'd0) & (w_pwb != '0);

    assign w_inc_v = w_inc ? (32'd1 << issue_rd) : 32'd0;
    assign w_dec_v = w_dec ? (32'd1 << wb_rd) : 32'd0;

    assign fwd1 = issue_rs1_used & (issue_rs1 != 5'd0)
                & (w_ret1 | (r_last_we & (r_last_rd == issue_rs1)
                             & (w_p1 == '0)));
    assign fwd2 = issue_rs2_used & (issue_rs2 != 5'd0)
                & (w_ret2 | (r_last_we & (r_last_rd == issue_rs2)
                             & (w_p2 == '0)));

    assign pending_any = (r_total != '0);
    assign err         = r_err;

    // Entry 0 is held at zero so x0 never looks pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_pend[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_inc_v[i] & ~w_dec_v[i])
                    r_pend[i] <= r_pend[i] + PEND_ONE;
                else if (w_dec_v[i] & ~w_inc_v[i])
                    r_pend[i] <= r_pend[i] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total <= '0;
        end else if (w_inc & ~w_dec) begin
            r_total <= r_total + TOT_W'(1);
        end else if (w_dec & ~w_inc) begin
            r_total <= r_total - TOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_rd <= 5'd0;
            r_last_we <= 1'b0;
        end else if (w_accept & ~issue_long) begin
            r_last_rd <= issue_rd;
            r_last_we <= issue_we & (issue_rd != 5'd0);
        end else begin
            r_last_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (wb_valid & ~w_dec) begin
            r_err <= 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_stall & ~(&r_stall)) begin
            r_stall <= r_stall + STAT_W'(1);
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/reg_hazard_ctrl.md
Name: reg_hazard_ctrl

Overview:
Hazard and forwarding controller for the 32x32 register file in the RISC-V core. It tracks outstanding long-latency writes (loads, CSR reads) per architectural register. It stalls instruction issue on read-after-write and write-after-write hazards, and generates the two write-forward selects that sit beside the register file read ports. It is placed between decode/issue and the register file write port.

Parameters:
CNT_W, 2, width of the per-register outstanding-write counter; max pending per register = 2^CNT_W-1
MAX_OUT, 4, maximum total outstanding long writes across all registers
STAT_W, 32, width of the stall statistics counter

Ports:
clk  input  1  core clock
rst  input  1  reset; asynchronous, active-high
issue_valid  input  1  decode presents an instruction
issue_ready  output  1  instruction accepted this cycle (combinational)
issue_rs1  input  5  source 1 address
issue_rs2  input  5  source 2 address
issue_rs1_used  input  1  instruction reads rs1
issue_rs2_used  input  1  instruction reads rs2
issue_rd  input  5  destination address
issue_we  input  1  instruction writes rd
issue_long  input  1  result returns later via wb_* (load/CSR)
wb_valid  input  1  long-latency result written to register file this cycle
wb_rd  input  5  destination of that writeback
fwd1  output  1  select writeback/ALU bypass for read port 1
fwd2  output  1  select bypass for read port 2
pending_any  output  1  at least one long write outstanding
err  output  1  sticky protocol error
stall_cycles  output  STAT_W  stall count (see Optional Feature)

Behaviour:
- State: pend[1..31] (CNT_W each), total (outstanding sum), last_rd (5), last_we (1), err. x0 is never tracked. pend[0] reads as 0.
- Reset (async, immediate): all pend=0, total=0, last_we=0, last_rd=0, err=0, stall_cycles=0. Outputs after reset: issue_ready follows the combinational rule below (1 when issue_valid, no hazard), fwd1=fwd2=0, pending_any=0, err=0.
- Accept = issue_valid & issue_ready.
- Retire(r) = wb_valid & wb_rd==r & pend[r]==1. This is the last outstanding write to r completing this cycle.
- Source hazard on rsN: rsN_used & rsN!=0 & pend[rsN]!=0 & !Retire(rsN).
- issue_ready deasserts on any of:
  - source hazard on rs1 or rs2;
  - WAW: issue_we & issue_rd!=0 & pend[issue_rd]!=0 & !Retire(issue_rd);
  - issue_long & issue_we & issue_rd!=0 & total==MAX_OUT & !wb_valid.
- If issue_valid=0, issue_ready=1. No state changes.
- fwd1 (combinational) is 1 when rs1_used & rs1!=0 and either:
  - Retire(rs1), which bypasses write data in the same cycle; or
  - last_we & last_rd==rs1 & pend[rs1]==0, which bypasses the previous short op still in writeback.
- fwd2 uses the same rule on rs2.
- last_rd/last_we: on Accept with issue_long=0, last_rd<=issue_rd, last_we<=issue_we & issue_rd!=0. On Accept of a long op, or no Accept, last_we<=0. Latency is 1 cycle.
- Counters:
  - On Accept of a long write to rd!=0: pend[rd]+1, total+1.
  - On wb_valid with pend[wb_rd]!=0: pend[wb_rd]-1, total-1.
  - Both events to the same register in the same cycle: pend unchanged, total unchanged.
  - Different registers: both updates apply.
- pending_any = (total!=0), registered state.
- Errors, which set err sticky until rst:
  - wb_valid with wb_rd==0 or pend[wb_rd]==0: counter is not decremented.
  - Long issue that would overflow pend (pend==2^CNT_W-1): that case stalls instead, so err never sets from it.
- Reset mid-operation clears all pending state. In-flight writebacks arriving after reset set err.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: stall_cycles increments (saturating at all-ones) each cycle issue_valid=1 & issue_ready=0. It resets to 0.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset, then issue short add rd=5 and next cycle issue rs1=5 -> issue_ready=1, fwd1=1, fwd2=0; third cycle with no accept -> fwd1=0.
- Long load rd=7 accepted, then issue rs2=7 for 3 cycles with no wb -> issue_ready=0 for 3 cycles; cycle with wb_valid, wb_rd=7 -> issue_ready=1, fwd2=1, pend[7]=0, pending_any=0 next cycle.
- Issue long rd=0 and use rs1=0 -> never stalls, fwd1=0, total stays 0.
- Four long loads to rd=1..4 (MAX_OUT=4), fifth long to rd=9 -> stalled. Same cycle wb_rd=1 -> fifth accepted, total stays 4.
- Long issue rd=3 and wb_valid wb_rd=3 in the same cycle with pend[3]=1 -> pend[3] stays 1, total unchanged. wb_valid wb_rd=12 with pend[12]=0 -> err=1 and stays 1. Async rst mid-cycle -> err=0, pending_any=0 immediately.
- With HAZARD_STATS_EN: 5 stalled cycles then 2 accepted -> stall_cycles=5. Without the macro -> stall_cycles=0 throughout.
